seq_restoring_divider: RTL and testbench



---
 rtl/seq_restoring_divider_pkg.sv | 18 +
 rtl/div_trial_sub.sv | 18 +
 rtl/seq_restoring_divider.sv | 127 ++++++++++++
 tb/tb_seq_restoring_divider.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_restoring_divider_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_restoring_divider_pkg: shared state encoding and default width   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package seq_restoring_divider_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_CNT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage
`default_nettype wire

// File: rtl/div_trial_sub.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_trial_sub: combinational W-bit subtract with borrow out          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module div_trial_sub #(
  parameter int W = 5
) (
  input  logic [W-1:0] minuend,
  input  logic [W-1:0] subtrahend,
  output logic [W-1:0] diff,
  output logic         borrow
);

  assign {borrow, diff} = {1'b0, minuend} - {1'b0, subtrahend};

endmodule
`default_nettype wire

// File: rtl/seq_restoring_divider.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_restoring_divider: multi-cycle unsigned restoring divider        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  state_t state, state_next;

  logic [WIDTH:0]   rem_acc;
  logic [WIDTH-1:0] quo_acc;
  logic [WIDTH:0]   dsr;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] quo_next;
  logic             last_iter;
  logic             unused_rem_msb;

  // The partial remainder always stays below the divisor, so its MSB is
  // zero between iterations and only the low WIDTH bits feed the shift.
  assign shifted        = {rem_acc[WIDTH-1:0], quo_acc[WIDTH-1]};
  assign unused_rem_msb = rem_acc[WIDTH];

  div_trial_sub #(
    .W (WIDTH + 1)
  ) u_trial_sub (
    .minuend    (shifted),
    .subtrahend (dsr),
    .diff       (trial),
    .borrow     (borrow)
  );

  assign rem_next  = borrow ? shifted : trial;
  assign quo_next  = {quo_acc[WIDTH-2:0], ~borrow};
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = (divisor == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (last_iter) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_acc   <= '0;
      quo_acc   <= '0;
      dsr       <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (divisor != '0) begin
              rem_acc <= '0;
              quo_acc <= dividend;
              dsr     <= {1'b0, divisor};
              cnt     <= '0;
            end else begin
              quotient  <= '1;
              remainder <= dividend;
              div_zero  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          rem_acc <= rem_next;
          quo_acc <= quo_next;
          cnt     <= cnt + 1'b1;
          if (last_iter) begin
            quotient  <= quo_next;
            remainder <= rem_next[WIDTH-1:0];
            div_zero  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_restoring_divider.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_seq_restoring_divider: scoreboard bench for seq_restoring_divider |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_seq_restoring_divider;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] dividend = '0;
  logic [WIDTH-1:0] divisor = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;

  seq_restoring_divider #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dz;
  } exp_t;

  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;
  int   done_seen = 0;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer division, with the divide-by-zero convention
  function automatic exp_t model(input int a, input int b);
    exp_t e;
    if (b == 0) begin
      e.q  = '1;
      e.r  = WIDTH'(a);
      e.dz = 1'b1;
    end else begin
      e.q  = WIDTH'(a / b);
      e.r  = WIDTH'(a % b);
      e.dz = 1'b0;
    end
    return e;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && done) begin
      done_seen++;
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_done: got done with empty scoreboard (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        check("quotient", int'(quotient), int'(e.q));
        check("remainder", int'(remainder), int'(e.r));
        check("div_zero", int'(div_zero), int'(e.dz));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((busy || done) && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) check("idle_timeout", guard, 0);
  endtask

  task automatic run_op(input int a, input int b);
    int lat = 0;
    int busy_cnt = 0;
    wait_idle();
    dividend = WIDTH'(a);
    divisor  = WIDTH'(b);
    start    = 1'b1;
    sb.push_back(model(a, b));
    tick();
    start = 1'b0;
    busy_cnt = int'(busy);
    while (!done && lat < 40) begin
      tick();
      lat++;
      busy_cnt += int'(busy);
    end
    check("done_latency", lat, (b == 0) ? 0 : WIDTH);
    check("busy_cycles", busy_cnt, (b == 0) ? 0 : WIDTH);
  endtask

  initial begin : stim
    int d0;
    int lat;
    int ta[5] = '{15, 3, 0, 14, 15};
    int tb[5] = '{1, 5, 7, 3, 15};

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_quotient", int'(quotient), 0);
    check("rst_remainder", int'(remainder), 0);
    check("rst_div_zero", int'(div_zero), 0);

    run_op(7, 2);
    for (int i = 0; i < 5; i++) run_op(ta[i], tb[i]);

    run_op(9, 0);
    run_op(6, 4);
    repeat (3) tick();
    check("hold_quotient", int'(quotient), 1);
    check("hold_remainder", int'(remainder), 2);

    // Extra start and changing operands during RUN must be ignored
    wait_idle();
    d0 = done_seen;
    dividend = 4'd12;
    divisor  = 4'd5;
    start    = 1'b1;
    sb.push_back(model(12, 5));
    tick();
    start = 1'b0;
    tick();
    tick();
    start    = 1'b1;
    dividend = 4'd1;
    divisor  = 4'd1;
    lat = 2;
    while (!done && lat < 40) begin
      tick();
      lat++;
      dividend = WIDTH'($urandom);
    end
    check("ignored_start_latency", lat, WIDTH);
    start = 1'b0;
    repeat (8) tick();
    check("single_done_pulse", done_seen - d0, 1);

    // Asynchronous reset in the middle of RUN
    wait_idle();
    dividend = 4'd13;
    divisor  = 4'd2;
    start    = 1'b1;
    sb.push_back(model(13, 2));
    tick();
    start = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    void'(sb.pop_back());
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_quotient", int'(quotient), 0);
    check("arst_remainder", int'(remainder), 0);
    check("arst_div_zero", int'(div_zero), 0);
    d0 = done_seen;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) tick();
    check("arst_no_done", done_seen - d0, 0);
    run_op(10, 3);

    for (int i = 0; i < 40; i++) begin
      run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    end

    repeat (3) tick();
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
